// File: rtl/te_mult_arbiter.sv
// Round-robin arbiter sharing one Fc x (omega/Ac) multiplier among R/G/B channels.
// Two-stage issue/product pipeline with tagged results and output backpressure.
module te_mult_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int FC_W    = 8,
  parameter int COEF_W  = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [1:0]              cfg_sel,
  input  logic [COEF_W-1:0]       cfg_inv_ac,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FC_W-1:0] req_fc,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_tag,
  output logic [COEF_W-1:0]       out_product
);

  // Unsigned Q0.14 product; bits above the low COEF_W are discarded, never saturated.
  function automatic logic [COEF_W-1:0] trunc_mul(input logic [FC_W-1:0]   fc,
                                                  input logic [COEF_W-1:0] coef);
    logic [FC_W+COEF_W-1:0] full;
    full = {{COEF_W{1'b0}}, fc} * {{FC_W{1'b0}}, coef};
    return full[COEF_W-1:0];
  endfunction

  logic [COEF_W-1:0] coef_q [NUM_REQ];
  logic [1:0]        ptr_q, ptr_d;

  logic [FC_W-1:0]   fc_p0_q;
  logic [COEF_W-1:0] coef_p0_q;
  logic [1:0]        tag_p0_q;
  logic              vld_p0_q;

  logic [COEF_W-1:0] prod_p1_q;
  logic [1:0]        tag_p1_q;
  logic              vld_p1_q;

  logic              adv;
  logic              gnt_vld;
  logic [1:0]        gnt_idx;
  logic [2:0]        cand;
  logic [FC_W-1:0]   fc_sel;

  // Search from the lowest offset last so the channel nearest ptr wins.
  always_comb begin
    adv     = !vld_p1_q || out_ready;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (req_valid[cand[1:0]]) begin
        gnt_vld = adv;
        gnt_idx = cand[1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
    fc_sel = req_fc[gnt_idx*FC_W +: FC_W];
    ptr_d  = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == 2'(NUM_REQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) coef_q[i] <= '0;
      ptr_q     <= '0;
      fc_p0_q   <= '0;
      coef_p0_q <= '0;
      tag_p0_q  <= '0;
      vld_p0_q  <= 1'b0;
      prod_p1_q <= '0;
      tag_p1_q  <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      if (cfg_we && (cfg_sel < 2'(NUM_REQ))) coef_q[cfg_sel] <= cfg_inv_ac;
      ptr_q <= ptr_d;
      if (adv) begin
        // stage B: product register
        prod_p1_q <= trunc_mul(fc_p0_q, coef_p0_q);
        tag_p1_q  <= tag_p0_q;
        vld_p1_q  <= vld_p0_q;
        // stage A: issue register (coef read is pre-write, so same-cycle cfg uses old value)
        vld_p0_q  <= gnt_vld;
        if (gnt_vld) begin
          fc_p0_q   <= fc_sel;
          coef_p0_q <= coef_q[gnt_idx];
          tag_p0_q  <= gnt_idx;
        end
      end
    end
  end

  assign out_valid   = vld_p1_q;
  assign out_tag     = tag_p1_q;
  assign out_product = prod_p1_q;

endmodule

// File: doc/te_mult_arbiter.md
# te_mult_arbiter

Round-robin arbiter and sequencer that time-shares one transmission-estimation multiplier (Fc × scaled inverse atmospheric light) among three requesting channels (R, G, B). It holds per-channel Q0.14 ω/Ac coefficients, grants one request per cycle, and returns tagged Q0.14 products through a two-stage pipeline with output backpressure. It sits between the dark-channel filter outputs and the transmission-map subtractor.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (fixed; tag is 2 bits)
- FC_W, 8, filter-result width
- COEF_W, 14, Q0.14 coefficient and product width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  coefficient write strobe
- cfg_sel  in  2  coefficient index 0..2; 3 ignored
- cfg_inv_ac  in  14  ω·1/Ac, Q0.14
- req_valid  in  3  per-channel request valid
- req_fc  in  24  packed Fc, channel i at [8i+7:8i]
- req_ready  out  3  per-channel accept, one-hot or zero
- out_valid  out  1  product valid
- out_ready  in  1  downstream accept
- out_tag  out  2  channel index of product
- out_product  out  14  Q0.14 product

## Operation
- Coefficient bank: three 14-bit registers, reset to 0. Written when cfg_we=1 and cfg_sel<3; write takes effect the following cycle. cfg_sel=3 writes nothing.
- Pipeline: stage A (issue register: fc, coef, tag, valid) → stage B (product register: product, tag, valid). Stage B drives out_*.
- Advance condition adv = !B.valid | out_ready. When adv=0 both stages hold; no grant is issued.
- Stage A may accept a new request only when adv=1 (A moves to B in the same cycle).
- Arbitration: round-robin pointer ptr (reset 0) names the highest-priority channel; search order ptr, ptr+1, ptr+2 (mod 3). First channel with req_valid=1 is granted if adv=1. After a grant to channel g, ptr ← (g+1) mod 3. No grant → ptr unchanged.
- req_ready[g]=1 only for the granted channel; it is combinational from req_valid, ptr and adv. Handshake completes when req_valid[i] & req_ready[i].
- On grant: A.fc ← req_fc[g], A.coef ← coef[g] (value registered before this cycle's cfg write), A.tag ← g, A.valid ← 1. Adv with no grant: A.valid ← 0.
- On adv: B.product ← (A.fc × A.coef)[13:0] (22-bit unsigned product truncated to its low 14 bits, overflow discarded, no saturation); B.tag ← A.tag; B.valid ← A.valid.
- Reset mid-operation: all in-flight entries discarded, nothing emitted for them.

## Timing
- Reset values: req_ready=0 (combinationally, since pipeline empty permits grant only when req_valid present—after reset req_ready follows req_valid rules), out_valid=0, out_tag=0, out_product=0, ptr=0, coef regs=0, A/B valid=0.
- Latency: handshake in cycle N → out_valid=1 in cycle N+2 with no backpressure.
- Throughput: one product per cycle while out_ready=1.
- out_valid, out_tag, out_product remain stable while out_valid=1 and out_ready=0.
- With out_ready=0 and B full, req_ready=0 for all channels; resumes the cycle out_ready=1.
- Simultaneous cfg write and grant on same channel: product uses old coefficient.
- Bubbles: A.valid=0 propagates as out_valid=0; no garbage emitted.

## Test plan
- Reset, then cfg coef[0]=0x0100, ch0 request Fc=100 → req_ready=3'b001 same cycle, two cycles later out_valid=1, out_tag=0, out_product=0x2400.
- Truncation: coef[2]=0x3FFF, ch2 Fc=255 → out_product=0x3F01, out_tag=2; Fc=0 → 0x0000.
- All three req_valid held high continuously from reset → grants 0,1,2,0,1,2…, tags emitted in same order, one per cycle.
- Backpressure: stream active, drop out_ready for 4 cycles → out_* frozen, req_ready=0, no loss or duplication; resume yields remaining tags in order.
- Same-cycle cfg write coef[1]: 0x0100→0x0200 with ch1 Fc=10 grant → product 0x0A00; next ch1 Fc=10 → 0x1400.
- Assert rst with both stages full → next cycle out_valid=0, ptr=0, coefs=0; earlier entries never appear.
